// File: rtl/matrix_uart_parser.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_uart_parser                                                   |
// | Parses an ASCII decimal stream into row-major matrix element writes. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module matrix_uart_parser #(
  parameter int DATA_WIDTH = 9,
  parameter int ROWS       = 8,
  parameter int COLS       = 10,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  localparam int                    c_acc_w    = DATA_WIDTH + 4;
  localparam logic [c_acc_w-1:0]    c_max_val  = c_acc_w'((1 << DATA_WIDTH) - 1);
  localparam logic [c_acc_w-1:0]    c_ten      = c_acc_w'(10);
  localparam logic [ADDR_WIDTH-1:0] c_last_idx = ADDR_WIDTH'(ROWS * COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_idx_one  = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_SKIP         = 3'd1,
    S_ACCUM        = 3'd2,
    S_DONE         = 3'd3,
    S_WAIT_RELEASE = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_acc_w-1:0]    r_acc, w_acc_nxt;
  logic [c_acc_w-1:0]    w_digit, w_acc_mac;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
  logic                  r_err, w_err_nxt;
  logic                  w_emit, w_byte, w_is_digit, w_is_sep, w_ovf;
  logic                  r_busy, r_done, r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;

  assign w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign w_is_sep   = (rx_data == 8'h20) || (rx_data == 8'h0A) || (rx_data == 8'h0D);
  assign w_byte     = rx_valid && !abort;
  assign w_digit    = {{(c_acc_w-4){1'b0}}, rx_data[3:0]};
  // acc is held at or below c_max_val, so the product never wraps c_acc_w bits
  assign w_acc_mac  = r_acc * c_ten + w_digit;
  assign w_ovf      = w_acc_mac > c_max_val;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    w_err_nxt   = r_err;
    w_emit      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SKIP;
          w_acc_nxt   = '0;
          w_idx_nxt   = '0;
          w_err_nxt   = 1'b0;
        end
      end
      S_SKIP: begin
        if (w_byte) begin
          if (w_is_digit) begin
            w_acc_nxt   = w_digit;
            w_state_nxt = S_ACCUM;
          end else if (!w_is_sep) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (w_byte) begin
          if (w_is_digit) begin
            if (w_ovf) begin
              w_acc_nxt = c_max_val;
              w_err_nxt = 1'b1;
            end else begin
              w_acc_nxt = w_acc_mac;
            end
          end else if (w_is_sep) begin
            w_emit      = 1'b1;
            w_acc_nxt   = '0;
            w_idx_nxt   = r_idx + c_idx_one;
            w_state_nxt = (r_idx == c_last_idx) ? S_DONE : S_SKIP;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_DONE:         w_state_nxt = S_WAIT_RELEASE;
      S_WAIT_RELEASE: if (!start) w_state_nxt = S_IDLE;
      default:        w_state_nxt = S_IDLE;
    endcase
    // abort drops any number in progress but leaves err for inspection
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_err_nxt   = r_err;
      w_emit      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_idx     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt == S_SKIP) || (w_state_nxt == S_ACCUM) ||
                 (w_state_nxt == S_DONE);
      r_done  <= (r_state == S_DONE) && !abort;
      r_wr_en <= w_emit;
      if (w_emit) begin
        r_wr_addr <= r_idx;
        r_wr_data <= r_acc[DATA_WIDTH-1:0];
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_matrix_uart_parser.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matrix_uart_parser                                                |
// | Self-checking bench: randomized byte streams vs. a parsing model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_matrix_uart_parser;

  localparam int DW   = 9;
  localparam int RW   = 8;
  localparam int CL   = 10;
  localparam int AW   = 7;
  localparam int N    = RW * CL;
  localparam int MAXV = (1 << DW) - 1;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          busy, done, err, wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  int n_cmp = 0, n_fail = 0;

  logic [7:0]  stim[$];
  logic [15:0] obs[$];
  logic [15:0] expw[$];
  bit          exp_err, exp_done;

  int   cyc = 0, last_wr_cyc = -10, done_cyc = -1, done_cnt = 0, consec = 0;
  logic busy_at_done = 1'b0, prev_wr = 1'b0;
  int   base_w = 0, base_done = 0, base_consec = 0;

  matrix_uart_parser #(
    .DATA_WIDTH(DW), .ROWS(RW), .COLS(CL), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      obs.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
      if (prev_wr) consec++;
    end
    prev_wr = wr_en;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic mark();
    base_w      = obs.size();
    base_done   = done_cnt;
    base_consec = consec;
  endtask

  task automatic push_byte(input logic [7:0] b);
    stim.push_back(b);
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endtask

  task automatic push_num(input int v);
    push_str($sformatf("%0d", v));
  endtask

  // Reference: walk the text, build numbers by decimal arithmetic, clip to the element range.
  task automatic run_model();
    longint     v;
    bit         in_num;
    int         idx;
    logic [7:0] c;
    v = 0; in_num = 0; idx = 0;
    expw.delete();
    exp_err = 0;
    foreach (stim[i]) begin
      c = stim[i];
      if (idx < N) begin
        if (c >= 8'h30 && c <= 8'h39) begin
          v = v * 10 + longint'(c - 8'h30);
          in_num = 1;
          if (v > MAXV) begin exp_err = 1; v = MAXV + 1; end
        end else if (c == 8'h20 || c == 8'h0A || c == 8'h0D) begin
          if (in_num) begin
            expw.push_back({AW'(idx), DW'((v > MAXV) ? MAXV : v)});
            idx++; in_num = 0; v = 0;
          end
        end else begin
          exp_err = 1;
        end
      end
    end
    exp_done = (idx == N);
  endtask

  task automatic gen_random();
    int v, ns, sp;
    stim.delete();
    if ($urandom_range(1) == 1) push_str("  ");
    for (int k = 0; k < N + 3; k++) begin
      case ($urandom_range(9))
        0:       v = int'($urandom_range(9999, 512));
        1:       v = int'($urandom_range(9));
        default: v = int'($urandom_range(MAXV));
      endcase
      if ($urandom_range(19) == 0) begin
        push_num(v / 10); push_str("q"); push_num(v % 10);
      end else begin
        push_num(v);
      end
      ns = int'($urandom_range(3, 1));
      for (int s = 0; s < ns; s++) begin
        sp = int'($urandom_range(2));
        push_byte(sp == 0 ? 8'h20 : (sp == 1 ? 8'h0A : 8'h0D));
      end
      if ($urandom_range(29) == 0) push_str("#");
    end
  endtask

  task automatic start_load(input bit hold);
    mark();
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic feed(input int gap_pct, input int from);
    for (int i = from; i < stim.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        rx_valid = 1'b0;
        @(posedge clk); #1;
      end
      rx_valid = 1'b1;
      rx_data  = stim[i];
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && done_cnt == base_done; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    n_cmp++; if ({busy, done, err, wr_en} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, err, wr_en}); end
    n_cmp++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", wr_addr); end
    n_cmp++; if (wr_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", wr_data); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if ({busy, done, err, wr_en} !== 4'b0) begin n_fail++;
      $display("FAIL idle_flags: got %b want 0000", {busy, done, err, wr_en}); end
  endtask

  task automatic test_full_seq();
    stim.delete();
    for (int k = 0; k < N; k++) begin
      push_num(k);
      if (k % 10 == 9) push_str("\n"); else push_str(" ");
    end
    start_load(0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b want 1", busy); end
    feed(0, 0);
    wait_done();
    n_cmp++; if (obs.size() - base_w !== N) begin n_fail++;
      $display("FAIL full_nwrites: got %0d want %0d", obs.size() - base_w, N); end
    for (int i = 0; i < N && base_w + i < obs.size(); i++) begin
      n_cmp++; if (obs[base_w+i] !== {AW'(i), DW'(i)}) begin n_fail++;
        $display("FAIL full_write[%0d]: got addr %0d data %0d want addr %0d data %0d",
                 i, obs[base_w+i][15:9], obs[base_w+i][8:0], i, i); end
    end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b want 0", err); end
    n_cmp++; if (done_cnt - base_done !== 1) begin n_fail++;
      $display("FAIL full_done_cnt: got %0d want 1", done_cnt - base_done); end
    n_cmp++; if (done_cyc !== last_wr_cyc + 1) begin n_fail++;
      $display("FAIL full_done_timing: got cycle %0d want %0d", done_cyc, last_wr_cyc + 1); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_fail++;
      $display("FAIL full_busy_at_done: got %b want 0", busy_at_done); end
    n_cmp++; if (consec - base_consec !== 0) begin n_fail++;
      $display("FAIL full_wr_consec: got %0d want 0", consec - base_consec); end
  endtask

  task automatic test_back_to_back();
    stim.delete();
    push_str("511\n7  "); push_byte(8'h0D); push_str("\n  42 ");
    start_load(0);
    feed(0, 0);
    repeat (3) @(posedge clk); #1;
    run_model();
    n_cmp++; if (obs.size() - base_w !== 3) begin n_fail++;
      $display("FAIL b2b_nwrites: got %0d want 3", obs.size() - base_w); end
    foreach (expw[i]) if (base_w + i < obs.size()) begin
      n_cmp++; if (obs[base_w+i] !== expw[i]) begin n_fail++;
        $display("FAIL b2b_write[%0d]: got %h want %h", i, obs[base_w+i], expw[i]); end
    end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", err); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    pulse_abort();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    int first_len;
    stim.delete();
    push_str("600 ");
    first_len = stim.size();
    start_load(0);
    feed(0, 0);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (obs.size() - base_w !== 1 || obs[obs.size()-1] !== {AW'(0), DW'(MAXV)}) begin n_fail++;
      $display("FAIL ovf_first: got %0d writes last %h want 1 write %h",
               obs.size() - base_w, obs[obs.size()-1], {AW'(0), DW'(MAXV)}); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", err); end
    push_str("9x9 ");
    feed(3, first_len);
    repeat (3) @(posedge clk); #1;
    run_model();
    n_cmp++; if (obs.size() - base_w !== expw.size()) begin n_fail++;
      $display("FAIL ovf_nwrites: got %0d want %0d", obs.size() - base_w, expw.size()); end
    foreach (expw[i]) if (base_w + i < obs.size()) begin
      n_cmp++; if (obs[base_w+i] !== expw[i]) begin n_fail++;
        $display("FAIL ovf_write[%0d]: got %h want %h", i, obs[base_w+i], expw[i]); end
    end
    n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL ovf_err_sticky: got %b want %b", err, exp_err); end
    pulse_abort();
  endtask

  task automatic test_held_start();
    gen_random();
    run_model();
    start_load(1);
    feed(20, 0);
    wait_done();
    repeat (20) @(posedge clk); #1;
    n_cmp++; if (obs.size() - base_w !== expw.size()) begin n_fail++;
      $display("FAIL held_nwrites: got %0d want %0d", obs.size() - base_w, expw.size()); end
    foreach (expw[i]) if (base_w + i < obs.size()) begin
      n_cmp++; if (obs[base_w+i] !== expw[i]) begin n_fail++;
        $display("FAIL held_write[%0d]: got %h want %h", i, obs[base_w+i], expw[i]); end
    end
    n_cmp++; if (done_cnt - base_done !== 1) begin n_fail++;
      $display("FAIL held_done_cnt: got %0d want 1", done_cnt - base_done); end
    n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL held_err: got %b want %b", err, exp_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_no_retrigger: busy got %b want 0", busy); end
    start = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_release_busy: got %b want 0", busy); end
    start_load(0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_restart_busy: got %b want 1", busy); end
    pulse_abort();
  endtask

  task automatic test_abort();
    stim.delete();
    push_str("12 x3");
    start_load(0);
    feed(0, 0);
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h20;
    @(posedge clk); #1;
    abort    = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    run_model();
    n_cmp++; if (obs.size() - base_w !== expw.size()) begin n_fail++;
      $display("FAIL abort_nwrites: got %0d want %0d", obs.size() - base_w, expw.size()); end
    foreach (expw[i]) if (base_w + i < obs.size()) begin
      n_cmp++; if (obs[base_w+i] !== expw[i]) begin n_fail++;
        $display("FAIL abort_write[%0d]: got %h want %h", i, obs[base_w+i], expw[i]); end
    end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL abort_err_hold: got %b want 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (done_cnt - base_done !== 0) begin n_fail++;
      $display("FAIL abort_done: got %0d want 0", done_cnt - base_done); end
    stim.delete();
    push_str("5 ");
    start_load(0);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err_clear: got %b want 0", err); end
    feed(0, 0);
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (obs.size() - base_w !== 1 || obs[obs.size()-1] !== {AW'(0), DW'(5)}) begin n_fail++;
      $display("FAIL abort_new_load: got %0d writes last %h want 1 write %h",
               obs.size() - base_w, obs[obs.size()-1], {AW'(0), DW'(5)}); end
    pulse_abort();
  endtask

  task automatic test_reset_mid();
    stim.delete();
    push_str("3x45");
    start_load(0);
    feed(0, 0);
    n_cmp++; if ({busy, err} !== 2'b11) begin n_fail++;
      $display("FAIL rstmid_pre: got busy,err %b want 11", {busy, err}); end
    mark();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, err, wr_en} !== 4'b0 || wr_addr !== '0 || wr_data !== '0) begin n_fail++;
      $display("FAIL rstmid_outputs: got flags %b addr %0d data %0d want all 0",
               {busy, done, err, wr_en}, wr_addr, wr_data); end
    rx_valid = 1'b1; rx_data = 8'h20;
    repeat (3) @(posedge clk); #1;
    rx_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (obs.size() - base_w !== 0) begin n_fail++;
      $display("FAIL rstmid_no_write: got %0d writes want 0", obs.size() - base_w); end
  endtask

  task automatic test_random(input int iter);
    gen_random();
    run_model();
    start_load(0);
    feed(30, 0);
    wait_done();
    n_cmp++; if (obs.size() - base_w !== expw.size()) begin n_fail++;
      $display("FAIL rand%0d_nwrites: got %0d want %0d", iter, obs.size() - base_w, expw.size()); end
    foreach (expw[i]) if (base_w + i < obs.size()) begin
      n_cmp++; if (obs[base_w+i] !== expw[i]) begin n_fail++;
        $display("FAIL rand%0d_write[%0d]: got %h want %h", iter, i, obs[base_w+i], expw[i]); end
    end
    n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL rand%0d_err: got %b want %b", iter, err, exp_err); end
    n_cmp++; if ((done_cnt - base_done == 1) !== exp_done) begin n_fail++;
      $display("FAIL rand%0d_done: got %0d pulses want %0d", iter, done_cnt - base_done, exp_done); end
    n_cmp++; if (done_cyc !== last_wr_cyc + 1 || busy_at_done !== 1'b0) begin n_fail++;
      $display("FAIL rand%0d_done_timing: got cycle %0d busy %b want cycle %0d busy 0",
               iter, done_cyc, busy_at_done, last_wr_cyc + 1); end
    n_cmp++; if (consec - base_consec !== 0) begin n_fail++;
      $display("FAIL rand%0d_wr_consec: got %0d want 0", iter, consec - base_consec); end
  endtask

  initial begin
    test_reset();
    test_full_seq();
    test_back_to_back();
    test_overflow();
    test_held_start();
    test_abort();
    test_reset_mid();
    for (int it = 0; it < 3; it++) test_random(it);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
